// File: rtl/nest4_tile_addr_map.sv
// Maps a nested 4-level index tuple stream to linear tile addresses through a
// 2-stage back-pressured pipeline. Optional sequence checker: NEST4_SEQ_CHECK_EN.
module nest4_tile_addr_map #(
  parameter int unsigned CW     = 16,
  parameter int unsigned AW     = 32,
  parameter int unsigned N0_MAX = 4,
  parameter int unsigned N1_MAX = 2,
  parameter int unsigned N2_MAX = 2,
  parameter int unsigned N3_MAX = 3,
  parameter int unsigned S0     = 1,
  parameter int unsigned S1     = 4,
  parameter int unsigned S2     = 8,
  parameter int unsigned S3     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  input  logic [CW-1:0] cnt3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] S0_W = AW'(S0);
  localparam logic [AW-1:0] S1_W = AW'(S1);
  localparam logic [AW-1:0] S2_W = AW'(S2);
  localparam logic [AW-1:0] S3_W = AW'(S3);
  localparam logic [CW-1:0] M0   = CW'(N0_MAX - 1);
  localparam logic [CW-1:0] M1   = CW'(N1_MAX - 1);
  localparam logic [CW-1:0] M2   = CW'(N2_MAX - 1);
  localparam logic [CW-1:0] M3   = CW'(N3_MAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] s1_lo, s1_hi;
  logic          s1_valid, s1_last;
  logic          s2_adv, accept, in_last, out_fire, start_ok;

  // Handshake decode; in_ready drops combinationally when both stages are held.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = (state == RUN) && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign in_last  = (cnt0 == M0) && (cnt1 == M1) && (cnt2 == M2) && (cnt3 == M3);
  assign start_ok = (state == IDLE) && start;
  assign busy     = (state != IDLE);
  assign done     = (state == DRAIN) && out_fire && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) base_q <= '0;
    else if (start_ok) base_q <= base_addr;
  end

  // Stage 1: partial sums of the low and high index pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_last  <= 1'b0;
    end else if (!s1_valid || s2_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_lo   <= AW'(cnt0) * S0_W + AW'(cnt1) * S1_W;
        s1_hi   <= AW'(cnt2) * S2_W + AW'(cnt3) * S3_W;
        s1_last <= in_last;
      end
    end
  end

  // Stage 2: final address; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_addr <= base_q + s1_lo + s1_hi;
        out_last <= s1_last;
      end
    end
  end

`ifdef NEST4_SEQ_CHECK_EN
  logic [CW-1:0] e0, e1, e2, e3;
  logic          err_q;

  // Expected tuple walks as a nested counter, cnt0 fastest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      e3    <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      e3    <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if ((cnt0 != e0) || (cnt1 != e1) || (cnt2 != e2) || (cnt3 != e3)) err_q <= 1'b1;
      if (e0 != M0) begin
        e0 <= e0 + CW'(1);
      end else begin
        e0 <= '0;
        if (e1 != M1) begin
          e1 <= e1 + CW'(1);
        end else begin
          e1 <= '0;
          if (e2 != M2) begin
            e2 <= e2 + CW'(1);
          end else begin
            e2 <= '0;
            e3 <= (e3 != M3) ? e3 + CW'(1) : '0;
          end
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nest4_tile_addr_map.sv
// Directed scoreboard bench for nest4_tile_addr_map: nested tile streams,
// back-pressure, address wrap, ignored start, mid-tile reset, sequence error.
module tb_nest4_tile_addr_map;

`ifdef NEST4_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] tile_base;
  bit          done_seen;
  bit          err_pending;
  int          pops;

  nest4_tile_addr_map dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [15:0] c0, c1, c2, c3);
    exp_t e;
    e.addr = tile_base + 32'(c0) + 32'(c1) * 32'd4 + 32'(c2) * 32'd8 + 32'(c3) * 32'd16;
    e.last = (c0 == 16'd3) && (c1 == 16'd1) && (c2 == 16'd1) && (c3 == 16'd2);
    return e;
  endfunction

  // One clock: sample at negedge, then return just after the next rising edge.
  task automatic tick(input bit chk_stall, output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (chk_stall) chk("in_ready_stall", 32'(in_ready), 32'd0);
    if (err_pending) begin
      chk("err_after_bad", 32'(err), 32'(SEQ_EN));
      err_pending = 1'b0;
    end
    if (acc) sb.push_back(model(cnt0, cnt1, cnt2, cnt3));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_last", 32'(out_last), 32'(e.last));
        chk("done", 32'(done), 32'(e.last));
        if (e.last) begin
          chk("busy_at_done", 32'(busy), 32'd1);
          done_seen = 1'b1;
        end
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"},  out_addr,       32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  // Runs one tile; negative knobs disable stall, abort and restart.
  task automatic run_tile(input logic [31:0] base, input int stall_at, input int abort_at,
                          input int restart_at, input bit bad_first);
    bit acc;
    bit restarted;
    int idx;
    int cyc;
    base_addr = base;
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1'b0, acc);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_after_start", 32'(in_ready), 32'd1);
    tile_base   = base;
    idx         = 0;
    cyc         = 0;
    pops        = 0;
    done_seen   = 1'b0;
    restarted   = 1'b0;
    err_pending = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      in_valid = (idx < 48);
      cnt0 = 16'(idx % 4);
      cnt1 = 16'((idx / 4) % 2);
      cnt2 = 16'((idx / 8) % 2);
      cnt3 = 16'(idx / 16);
      if (bad_first && idx == 0) cnt0 = 16'd1;
      out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        start     = 1'b1;
        base_addr = 32'h2000;
        restarted = 1'b1;
      end else begin
        start     = 1'b0;
        base_addr = base;
      end
      tick(stall_at >= 0 && cyc > stall_at && cyc < stall_at + 5, acc);
      if (acc && bad_first && idx == 0) err_pending = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("pop_count", 32'(pops), 32'd48);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("in_ready_after_done", 32'(in_ready), 32'd0);
    chk("err_end", 32'(err), 32'(SEQ_EN && bad_first));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    cnt0 = '0; cnt1 = '0; cnt2 = '0; cnt3 = '0;
    out_ready = 1'b1;
    done_seen = 1'b0;
    err_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_tile(32'h0000_1000, -1, -1, -1, 1'b0);
    run_tile(32'h0000_1000, 20, -1, -1, 1'b0);
    run_tile(32'hFFFF_FFF0, -1, -1, -1, 1'b0);
    run_tile(32'h0000_1000, -1, -1, 20, 1'b0);
    run_tile(32'h0000_1000, -1, 10, -1, 1'b0);
    run_tile(32'h0000_1000, -1, -1, -1, 1'b0);
    run_tile(32'h0000_1000, -1, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
